// File: rtl/ysyx_23060278_lsu.sv
// Load/store unit: accepts one core memory request at a time, checks it for
// legality and alignment, issues a single aligned memory beat, and returns
// an extended load result (or an error) as a one-cycle response pulse.
//
// state | meaning
// IDLE  | ready for a new request
// MREQ  | memory request presented, waiting for mem_ready
// MWAIT | load issued, waiting for mem_rvalid
// RESP  | one-cycle response (rsp_valid) to the core
module ysyx_23060278_lsu #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_load,
  input  logic                req_store,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                rsp_valid,
  output logic [XLEN-1:0]     rsp_rdata,
  output logic                rsp_err,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_wstrb,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam bit IS32  = (XLEN == 32);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MREQ  = 2'd1,
    MWAIT = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic                load_q;
  logic                store_q;
  logic [2:0]          f3_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [XLEN-1:0]     wdata_q;
  logic                err_q;
  logic [XLEN-1:0]     rdata_q;

  logic                accept;
  logic                req_err;
  logic                misalign;
  logic [OFF_W-1:0]    off_q;
  logic [XLEN-1:0]     ld_shift;
  logic [XLEN-1:0]     ld_ext;
  logic                ld_sign;
  int                  ld_msb;
  logic [NB-1:0]       st_base;
  logic [XLEN-1:0]     st_dmask;
  logic [NB-1:0]       st_strb;
  logic [XLEN-1:0]     st_data;

  assign accept = req_valid && (state_q == IDLE);
  assign off_q  = addr_q[OFF_W-1:0];

  // Legality and alignment of the incoming request, decided at accept time
  always_comb begin
    misalign = 1'b0;
    case (req_funct3[1:0])
      2'b01:   misalign = req_addr[0];
      2'b10:   misalign = |req_addr[1:0];
      2'b11:   misalign = |req_addr[2:0];
      default: misalign = 1'b0;
    endcase
    req_err = 1'b0;
    if (req_load == req_store) begin
      req_err = 1'b1;
    end else if (req_load) begin
      if (req_funct3 == 3'b111) req_err = 1'b1;
      if (IS32 && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110))) req_err = 1'b1;
    end else begin
      if (IS32 && (req_funct3 >= 3'b011)) req_err = 1'b1;
      if (!IS32 && (req_funct3 >= 3'b100)) req_err = 1'b1;
    end
    if (misalign) req_err = 1'b1;
  end

  // Store lane placement: size mask and masked data moved up to the byte offset
  always_comb begin
    st_base  = '0;
    st_dmask = '0;
    for (int i = 0; i < NB; i++) begin
      st_base[i]        = (i < (1 << f3_q[1:0]));
      st_dmask[i*8 +: 8] = {8{st_base[i]}};
    end
    st_strb = st_base << off_q;
    st_data = (wdata_q & st_dmask) << {off_q, 3'b000};
  end

  // Load return: move the addressed bytes to lane 0, then sign/zero extend
  always_comb begin
    ld_shift = mem_rdata >> {off_q, 3'b000};
    ld_msb   = XLEN - 1;
    ld_sign  = 1'b0;
    case (f3_q[1:0])
      2'b00: begin ld_msb = 7;  ld_sign = ld_shift[7];  end
      2'b01: begin ld_msb = 15; ld_sign = ld_shift[15]; end
      2'b10: begin ld_msb = 31; ld_sign = ld_shift[31]; end
      default: begin ld_msb = XLEN - 1; ld_sign = 1'b0; end
    endcase
    if (f3_q[2]) ld_sign = 1'b0;
    ld_ext = '0;
    for (int i = 0; i < XLEN; i++) begin
      ld_ext[i] = (i <= ld_msb) ? ld_shift[i] : ld_sign;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = req_err ? RESP : MREQ;
      MREQ:    if (mem_ready) state_d = store_q ? RESP : MWAIT;
      MWAIT:   if (mem_rvalid) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture and load-result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q  <= 1'b0;
      store_q <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else if (accept) begin
      load_q  <= req_load;
      store_q <= req_store;
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      err_q   <= req_err;
      rdata_q <= '0;
    end else if ((state_q == MWAIT) && mem_rvalid) begin
      rdata_q <= ld_ext;
    end
  end

  // Outputs, all qualified by state so nothing leaks outside its phase
  always_comb begin
    req_ready = (state_q == IDLE);
    mem_valid = (state_q == MREQ);
    mem_wen   = (state_q == MREQ) && store_q;
    mem_addr  = '0;
    mem_wstrb = '0;
    mem_wdata = '0;
    if (state_q == MREQ) begin
      mem_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      if (store_q) begin
        mem_wstrb = st_strb;
        mem_wdata = st_data;
      end
    end
    rsp_valid = (state_q == RESP);
    rsp_err   = (state_q == RESP) && err_q;
    rsp_rdata = (state_q == RESP) ? rdata_q : '0;
  end

  logic unused_ok;
  assign unused_ok = load_q;

endmodule

// File: tb/tb_ysyx_23060278_lsu.sv
// Bench for the LSU: 32-bit instance driven from a vector table with a
// memory responder and response scoreboard; 64-bit instance checked by hand.
module tb_ysyx_23060278_lsu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        req_valid = 0, req_ready, req_load = 0, req_store = 0;
  logic [2:0]  req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_valid, mem_ready = 0, mem_wen, mem_rvalid = 0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  logic [3:0]  mem_wstrb;

  // 64-bit instance
  logic        req_valid_64 = 0, req_ready_64, req_load_64 = 0, req_store_64 = 0;
  logic [2:0]  req_funct3_64 = 0;
  logic [31:0] req_addr_64 = 0;
  logic [63:0] req_wdata_64 = 0;
  logic        rsp_valid_64, rsp_err_64;
  logic [63:0] rsp_rdata_64;
  logic        mem_valid_64, mem_ready_64 = 1, mem_wen_64, mem_rvalid_64 = 0;
  logic [31:0] mem_addr_64;
  logic [63:0] mem_wdata_64, mem_rdata_64 = 0;
  logic [7:0]  mem_wstrb_64;

  ysyx_23060278_lsu #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  ysyx_23060278_lsu #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_64), .req_ready(req_ready_64), .req_load(req_load_64),
    .req_store(req_store_64), .req_funct3(req_funct3_64), .req_addr(req_addr_64),
    .req_wdata(req_wdata_64), .rsp_valid(rsp_valid_64), .rsp_rdata(rsp_rdata_64),
    .rsp_err(rsp_err_64), .mem_valid(mem_valid_64), .mem_ready(mem_ready_64),
    .mem_wen(mem_wen_64), .mem_addr(mem_addr_64), .mem_wdata(mem_wdata_64),
    .mem_wstrb(mem_wstrb_64), .mem_rvalid(mem_rvalid_64), .mem_rdata(mem_rdata_64)
  );

  typedef struct {
    logic ld; logic st; logic [2:0] f3;
    logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata;
    int stall; bit junk;
    logic e_err; logic [31:0] e_rdata; logic [31:0] e_addr;
    logic [3:0] e_wstrb; logic [31:0] e_wdata; int e_lat;
  } vec_t;

  typedef struct {
    logic [31:0] addr; logic wen; logic [3:0] wstrb; logic [31:0] wdata;
    logic [31:0] rdata; int stall; bit junk;
  } mreq_t;

  typedef struct { logic err; logic [31:0] rdata; int lat; } rsp_t;

  vec_t  vecs[$];
  mreq_t mreq_q[$];
  rsp_t  rsp_q[$];
  rsp_t  r;

  int checks = 0, errors = 0;
  int cyc = 0, acc_cyc = 0, spur = 0, spur_before = 0, stall_left = 0;
  bit in_req = 0, rv_pending = 0, rv_hold = 0;
  logic [31:0] rv_data = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic ld, input logic st, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] rdata, input int stall, input bit junk,
                     input logic e_err, input logic [31:0] e_rdata,
                     input logic [31:0] e_addr, input logic [3:0] e_wstrb,
                     input logic [31:0] e_wdata, input int e_lat);
    vec_t v;
    v = '{ld, st, f3, addr, wdata, rdata, stall, junk, e_err, e_rdata, e_addr, e_wstrb, e_wdata, e_lat};
    vecs.push_back(v);
  endtask

  // Memory responder and response scoreboard for the 32-bit instance
  always @(negedge clk) begin
    if (rv_pending && !rv_hold) begin
      mem_rvalid = 1; mem_rdata = rv_data; rv_pending = 0;
    end else if (mem_valid && mreq_q.size() > 0 && mreq_q[0].junk) begin
      mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    end else begin
      mem_rvalid = 0; mem_rdata = '0;
    end
    mem_ready = 0;
    if (rst_n && mem_valid) begin
      if (mreq_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_mem_valid: got 1 expected 0");
      end else begin
        if (!in_req) begin in_req = 1; stall_left = mreq_q[0].stall; end
        check("mem_addr",  mem_addr,  mreq_q[0].addr);
        check("mem_wen",   mem_wen,   mreq_q[0].wen);
        check("mem_wstrb", mem_wstrb, mreq_q[0].wstrb);
        check("mem_wdata", mem_wdata, mreq_q[0].wdata);
        check("req_ready_busy", req_ready, 0);
        if (stall_left > 0) stall_left--;
        else begin
          mem_ready = 1; in_req = 0;
          if (!mreq_q[0].wen) begin rv_pending = 1; rv_data = mreq_q[0].rdata; end
          void'(mreq_q.pop_front());
        end
      end
    end
    if (rsp_valid) begin
      if (rsp_q.size() == 0) spur++;
      else begin
        r = rsp_q.pop_front();
        check("rsp_err",   rsp_err,   r.err);
        check("rsp_rdata", rsp_rdata, r.rdata);
        if (r.lat > 0) check("rsp_latency", cyc - acc_cyc + 1, r.lat);
      end
    end
  end

  task automatic send(input vec_t v);
    int n;
    mreq_t m;
    rsp_t  e;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check("req_ready_idle", req_ready, 1);
    if (!v.e_err) begin
      m = '{v.e_addr, v.st, v.e_wstrb, v.e_wdata, v.rdata, v.stall, v.junk};
      mreq_q.push_back(m);
    end
    e = '{v.e_err, v.e_rdata, v.e_lat};
    rsp_q.push_back(e);
    @(negedge clk);
    req_valid = 1; req_load = v.ld; req_store = v.st; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    req_valid = 0;
    n = 0;
    while (rsp_q.size() != 0 && n < 60) begin @(negedge clk); n++; end
    check("rsp_pending", rsp_q.size(), 0);
    rsp_q.delete(); mreq_q.delete(); in_req = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_err"},   rsp_err,   0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_mem_valid"}, mem_valid, 0);
    check({tag, "_mem_wen"},   mem_wen,   0);
    check({tag, "_mem_addr"},  mem_addr,  0);
    check({tag, "_mem_wstrb"}, mem_wstrb, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  task automatic t64(input string tag, input logic ld, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [63:0] wdata,
                     input logic [63:0] rdata, input logic [31:0] e_addr,
                     input logic [7:0] e_strb, input logic [63:0] e_wdata,
                     input logic [63:0] e_rdata);
    @(negedge clk);
    req_valid_64 = 1; req_load_64 = ld; req_store_64 = !ld; req_funct3_64 = f3;
    req_addr_64 = addr; req_wdata_64 = wdata;
    @(posedge clk);
    #1 req_valid_64 = 0;
    @(negedge clk);
    check({tag, "_mem_valid"}, mem_valid_64, 1);
    check({tag, "_mem_addr"},  mem_addr_64,  e_addr);
    check({tag, "_mem_wen"},   mem_wen_64,   !ld);
    check({tag, "_mem_wstrb"}, mem_wstrb_64, e_strb);
    check({tag, "_mem_wdata"}, mem_wdata_64, e_wdata);
    @(posedge clk);
    #1;
    if (ld) begin
      mem_rvalid_64 = 1; mem_rdata_64 = rdata;
      @(posedge clk);
      #1 mem_rvalid_64 = 0;
    end
    @(negedge clk);
    check({tag, "_rsp_valid"}, rsp_valid_64, 1);
    check({tag, "_rsp_err"},   rsp_err_64,   0);
    check({tag, "_rsp_rdata"}, rsp_rdata_64, e_rdata);
    @(negedge clk);
  endtask

  initial begin
    vec_t rv;
    //  ld st f3    addr          wdata         rdata        stall junk err e_rdata       e_addr        strb  e_wdata       lat
    add(0, 1, 3'b000, 32'h80000003, 32'h123456AB, 32'h0,        0, 0, 0, 32'h0,        32'h80000000, 4'h8, 32'hAB000000, 2);
    add(1, 0, 3'b001, 32'h80000002, 32'h0,        32'h80010000, 0, 0, 0, 32'hFFFF8001, 32'h80000000, 4'h0, 32'h0,        3);
    add(1, 0, 3'b101, 32'h80000002, 32'h0,        32'h80010000, 0, 0, 0, 32'h00008001, 32'h80000000, 4'h0, 32'h0,        3);
    add(1, 0, 3'b010, 32'h80000006, 32'h0,        32'h0,        0, 0, 1, 32'h0,        32'h0,        4'h0, 32'h0,        1);
    add(1, 0, 3'b011, 32'h80000000, 32'h0,        32'h0,        0, 0, 1, 32'h0,        32'h0,        4'h0, 32'h0,        1);
    add(0, 1, 3'b001, 32'h80000002, 32'hCAFEBEEF, 32'h0,        0, 0, 0, 32'h0,        32'h80000000, 4'hC, 32'hBEEF0000, 2);
    add(0, 1, 3'b010, 32'h80000004, 32'h11223344, 32'h0,        0, 0, 0, 32'h0,        32'h80000004, 4'hF, 32'h11223344, 2);
    add(1, 0, 3'b000, 32'h80000001, 32'h0,        32'h0000F600, 0, 0, 0, 32'hFFFFFFF6, 32'h80000000, 4'h0, 32'h0,        3);
    add(1, 0, 3'b100, 32'h80000001, 32'h0,        32'h0000F600, 0, 0, 0, 32'h000000F6, 32'h80000000, 4'h0, 32'h0,        3);
    add(1, 0, 3'b010, 32'h80000008, 32'h0,        32'h89ABCDEF, 0, 0, 0, 32'h89ABCDEF, 32'h80000008, 4'h0, 32'h0,        3);
    add(1, 1, 3'b010, 32'h80000000, 32'h0,        32'h0,        0, 0, 1, 32'h0,        32'h0,        4'h0, 32'h0,        1);
    add(0, 0, 3'b010, 32'h80000000, 32'h0,        32'h0,        0, 0, 1, 32'h0,        32'h0,        4'h0, 32'h0,        1);
    add(0, 1, 3'b001, 32'h80000001, 32'h0,        32'h0,        0, 0, 1, 32'h0,        32'h0,        4'h0, 32'h0,        1);
    add(0, 1, 3'b011, 32'h80000000, 32'h0,        32'h0,        0, 0, 1, 32'h0,        32'h0,        4'h0, 32'h0,        1);
    add(1, 0, 3'b111, 32'h80000000, 32'h0,        32'h0,        0, 0, 1, 32'h0,        32'h0,        4'h0, 32'h0,        1);
    add(1, 0, 3'b110, 32'h80000000, 32'h0,        32'h0,        0, 0, 1, 32'h0,        32'h0,        4'h0, 32'h0,        1);
    add(0, 1, 3'b010, 32'h80000010, 32'hA5A5A5A5, 32'h0,        5, 0, 0, 32'h0,        32'h80000010, 4'hF, 32'hA5A5A5A5, 0);
    add(1, 0, 3'b000, 32'h80000003, 32'h0,        32'h7F000000, 2, 1, 0, 32'h0000007F, 32'h80000000, 4'h0, 32'h0,        0);

    #2;
    check_reset_outputs("por");
    repeat (3) @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < vecs.size(); i++) send(vecs[i]);

    // Reset while a load sits in MWAIT; the late read data must be ignored
    rv_hold = 1;
    mreq_q.push_back('{32'h80000020, 1'b0, 4'h0, 32'h0, 32'h00005555, 0, 1'b0});
    rsp_q.push_back('{1'b0, 32'h00005555, 0});
    @(negedge clk);
    req_valid = 1; req_load = 1; req_store = 0; req_funct3 = 3'b010;
    req_addr = 32'h80000020; req_wdata = 0;
    @(posedge clk);
    #1 req_valid = 0;
    @(posedge clk);
    #2 check("mwait_busy", req_ready, 0);
    rst_n = 0;
    #1;
    check_reset_outputs("abort");
    rsp_q.delete(); mreq_q.delete(); in_req = 0;
    spur_before = spur;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    rv_hold = 0;
    repeat (5) @(negedge clk);
    check("no_rsp_after_abort", spur, spur_before);
    rv = '{1, 0, 3'b010, 32'h80000024, 32'h0, 32'h13579BDF, 0, 0, 0, 32'h13579BDF, 32'h80000024, 4'h0, 32'h0, 3};
    send(rv);

    t64("lwu64", 1, 3'b110, 32'h80000004, 64'h0, 64'h87654321_00000000,
        32'h80000000, 8'h00, 64'h0, 64'h00000000_87654321);
    t64("lw64",  1, 3'b010, 32'h80000004, 64'h0, 64'h87654321_00000000,
        32'h80000000, 8'h00, 64'h0, 64'hFFFFFFFF_87654321);
    t64("sd64",  0, 3'b011, 32'h80000008, 64'h01234567_89ABCDEF, 64'h0,
        32'h80000008, 8'hFF, 64'h01234567_89ABCDEF, 64'h0);

    check("spurious_rsp_total", spur, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1);
  end

endmodule
